// File: rtl/pc_gen_btb_if.sv
// Fetch-PC unit interface: redirect sources, BTB training and the fetch PC / prediction.
// The master drives the redirect and training inputs; the slave is the PC generator.
interface pc_gen_btb_if #(
    parameter int XLEN = 64
);
    logic            trap_valid;
    logic [XLEN-1:0] trap_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            stall;
    logic            if_jump_valid;
    logic [XLEN-1:0] if_jump_pc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic [XLEN-1:0] upd_target;
    logic            upd_taken;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    modport master (
        output trap_valid, trap_pc, redirect_valid, redirect_pc, stall,
               if_jump_valid, if_jump_pc, upd_valid, upd_pc, upd_target, upd_taken,
        input  pc, pc_valid, pred_taken, pred_target
    );

    modport slave (
        input  trap_valid, trap_pc, redirect_valid, redirect_pc, stall,
               if_jump_valid, if_jump_pc, upd_valid, upd_pc, upd_target, upd_taken,
        output pc, pc_valid, pred_taken, pred_target
    );
endinterface

// File: rtl/pc_gen_btb.sv
// Next-PC generator with a direct-mapped branch target buffer (2-bit counters),
// looked up on the current fetch PC and trained by EX-stage branch resolution.
module pc_gen_btb #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int              BTB_ENTRIES = 16,
    parameter int              INST_BYTES  = 4
) (
    input  logic         clk,
    input  logic         rst,
    pc_gen_btb_if.slave  bus
);
    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int OFF  = $clog2(INST_BYTES);
    localparam int TAGW = XLEN - OFF - IDX;

    logic [XLEN-1:0]        r_pc;
    logic                   r_pc_valid;
    logic [BTB_ENTRIES-1:0] r_valid;
    logic [TAGW-1:0]        r_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        r_target [BTB_ENTRIES];
    logic [1:0]             r_ctr    [BTB_ENTRIES];

    logic [IDX-1:0]  w_lk_idx;
    logic [TAGW-1:0] w_lk_tag;
    logic            w_lk_hit;
    logic            w_pred_taken;
    logic [XLEN-1:0] w_pred_target;
    logic [XLEN-1:0] w_next_pc;
    logic [IDX-1:0]  w_up_idx;
    logic [TAGW-1:0] w_up_tag;
    logic            w_up_hit;
    logic [1:0]      w_ctr_cur;
    logic [1:0]      w_ctr_next;

    assign w_lk_idx = r_pc[OFF+IDX-1:OFF];
    assign w_lk_tag = r_pc[XLEN-1:OFF+IDX];
    assign w_up_idx = bus.upd_pc[OFF+IDX-1:OFF];
    assign w_up_tag = bus.upd_pc[XLEN-1:OFF+IDX];

    // Combinational BTB lookup on the current fetch PC (sees pre-update contents).
    always_comb begin
        w_lk_hit      = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
        w_pred_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
        w_pred_target = '0;
        if (w_pred_taken) begin
            w_pred_target = r_target[w_lk_idx];
        end else begin
            w_pred_target = '0;
        end
    end

    // Next-PC priority select; PC holds until the unit has left reset.
    always_comb begin
        w_next_pc = r_pc;
        if (!r_pc_valid) begin
            w_next_pc = r_pc;
        end else if (bus.trap_valid) begin
            w_next_pc = bus.trap_pc;
        end else if (bus.redirect_valid) begin
            w_next_pc = bus.redirect_pc;
        end else if (bus.stall) begin
            w_next_pc = r_pc;
        end else if (bus.if_jump_valid) begin
            w_next_pc = bus.if_jump_pc;
        end else if (w_pred_taken) begin
            w_next_pc = w_pred_target;
        end else begin
            w_next_pc = r_pc + XLEN'(INST_BYTES);
        end
    end

    // Saturating counter step for the entry being trained.
    always_comb begin
        w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
        w_ctr_cur  = r_ctr[w_up_idx];
        w_ctr_next = w_ctr_cur;
        case (bus.upd_taken)
            1'b1:    w_ctr_next = (w_ctr_cur == 2'b11) ? w_ctr_cur : w_ctr_cur + 2'd1;
            1'b0:    w_ctr_next = (w_ctr_cur == 2'b00) ? w_ctr_cur : w_ctr_cur - 2'd1;
            default: w_ctr_next = w_ctr_cur;
        endcase
    end

    // Fetch PC and its valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_VEC;
            r_pc_valid <= 1'b0;
        end else begin
            r_pc       <= w_next_pc;
            r_pc_valid <= 1'b1;
        end
    end

    // BTB valid bits: only a taken miss allocates; reset invalidates everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (bus.upd_valid && !w_up_hit && bus.upd_taken) begin
            r_valid[w_up_idx] <= 1'b1;
        end else begin
            r_valid <= r_valid;
        end
    end

    // BTB payload; contents behind a cleared valid bit are never observed.
    always_ff @(posedge clk) begin
        if (rst && bus.upd_valid) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= w_ctr_next;
                if (bus.upd_taken) begin
                    r_target[w_up_idx] <= bus.upd_target;
                end
            end else if (bus.upd_taken) begin
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= bus.upd_target;
                r_ctr[w_up_idx]    <= 2'b10;
            end
        end
    end

    assign bus.pc          = r_pc;
    assign bus.pc_valid    = r_pc_valid;
    assign bus.pred_taken  = w_pred_taken;
    assign bus.pred_target = w_pred_target;
endmodule

// File: tb/tb_pc_gen_btb.sv
// Directed bench for pc_gen_btb: priority, BTB allocation, counter saturation,
// aliasing, wrap-around, same-cycle update and asynchronous reset.
module tb_pc_gen_btb;
    logic clk;
    logic rst;
    int   n_errs   = 0;
    int   n_checks = 0;

    pc_gen_btb_if #(.XLEN(64)) bif ();

    pc_gen_btb #(
        .XLEN(64), .RESET_VEC(64'h0), .BTB_ENTRIES(16), .INST_BYTES(4)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [63:0] addr);
        bif.redirect_valid = 1'b1;
        bif.redirect_pc    = addr;
        tick();
        bif.redirect_valid = 1'b0;
    endtask

    task automatic train(input logic [63:0] bpc, input logic [63:0] tgt, input logic tk);
        bif.upd_valid  = 1'b1;
        bif.upd_pc     = bpc;
        bif.upd_target = tgt;
        bif.upd_taken  = tk;
        tick();
        bif.upd_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bif.trap_valid = 1'b0;     bif.trap_pc = 64'h0;
        bif.redirect_valid = 1'b0; bif.redirect_pc = 64'h0;
        bif.stall = 1'b0;
        bif.if_jump_valid = 1'b0;  bif.if_jump_pc = 64'h0;
        bif.upd_valid = 1'b0;      bif.upd_pc = 64'h0;
        bif.upd_target = 64'h0;    bif.upd_taken = 1'b0;
        repeat (2) tick();
        chk("rst_pc", bif.pc, 64'h0);
        chk("rst_valid", {63'h0, bif.pc_valid}, 64'h0);
        chk("rst_pred", {63'h0, bif.pred_taken}, 64'h0);

        // Sequential fetch after reset release
        rst = 1'b1;
        tick(); chk("seq0_pc", bif.pc, 64'h0); chk("seq0_valid", {63'h0, bif.pc_valid}, 64'h1);
        tick(); chk("seq1_pc", bif.pc, 64'h4);
        tick(); chk("seq2_pc", bif.pc, 64'h8);
        tick(); chk("seq3_pc", bif.pc, 64'hC);
        chk("seq_pred", {63'h0, bif.pred_taken}, 64'h0);

        // Priority
        go(64'h100); chk("redir_pc", bif.pc, 64'h100);
        bif.trap_valid = 1'b1;     bif.trap_pc = 64'h8000_0000;
        bif.redirect_valid = 1'b1; bif.redirect_pc = 64'h200;
        bif.stall = 1'b1;
        bif.if_jump_valid = 1'b1;  bif.if_jump_pc = 64'h300;
        tick(); chk("prio_trap", bif.pc, 64'h8000_0000);
        bif.trap_valid = 1'b0; bif.if_jump_valid = 1'b0;
        tick(); chk("prio_redir", bif.pc, 64'h200);
        bif.redirect_valid = 1'b0;
        tick(); chk("stall_hold1", bif.pc, 64'h200);
        bif.if_jump_valid = 1'b1;
        tick(); chk("stall_ignores_jump", bif.pc, 64'h200);
        bif.stall = 1'b0;
        tick(); chk("if_jump", bif.pc, 64'h300);
        bif.if_jump_valid = 1'b0;

        // Allocate and predict
        train(64'h40, 64'h400, 1'b1);
        go(64'h40);
        chk("alloc_pred", {63'h0, bif.pred_taken}, 64'h1);
        chk("alloc_tgt", bif.pred_target, 64'h400);
        tick(); chk("alloc_next", bif.pc, 64'h400);
        chk("tgt_pc_pred", {63'h0, bif.pred_taken}, 64'h0);
        chk("tgt_pc_tgt0", bif.pred_target, 64'h0);

        // Counter down to 0 then saturate up to 3
        for (int i = 0; i < 3; i++) train(64'h40, 64'h999, 1'b0);
        go(64'h40);
        chk("ctr0_pred", {63'h0, bif.pred_taken}, 64'h0);
        chk("ctr0_tgt", bif.pred_target, 64'h0);
        tick(); chk("ctr0_fall", bif.pc, 64'h44);
        train(64'h40, 64'h400, 1'b1);
        go(64'h40); chk("ctr1_pred", {63'h0, bif.pred_taken}, 64'h0);
        for (int i = 0; i < 3; i++) train(64'h40, 64'h400, 1'b1);
        go(64'h40); chk("ctr3_pred", {63'h0, bif.pred_taken}, 64'h1);
        train(64'h40, 64'h999, 1'b0);
        go(64'h40);
        chk("ctr3dec_pred", {63'h0, bif.pred_taken}, 64'h1);
        chk("ctr3dec_tgt", bif.pred_target, 64'h400);

        // Aliasing 0x40 / 0x80
        train(64'h80, 64'h800, 1'b1);
        go(64'h40); chk("alias_old", {63'h0, bif.pred_taken}, 64'h0);
        tick(); chk("alias_old_next", bif.pc, 64'h44);
        go(64'h80);
        chk("alias_new_pred", {63'h0, bif.pred_taken}, 64'h1);
        chk("alias_new_tgt", bif.pred_target, 64'h800);
        tick(); chk("alias_new_next", bif.pc, 64'h800);

        // Wrap
        go(64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_pred", {63'h0, bif.pred_taken}, 64'h0);
        tick(); chk("wrap_pc", bif.pc, 64'h0);

        // Same-cycle update and lookup
        train(64'h10C, 64'hA00, 1'b1);
        go(64'h10C);
        chk("same_pre_tgt", bif.pred_target, 64'hA00);
        bif.upd_valid = 1'b1; bif.upd_pc = 64'h10C;
        bif.upd_target = 64'hB00; bif.upd_taken = 1'b1;
        #1;
        chk("same_lookup_old", bif.pred_target, 64'hA00);
        tick(); bif.upd_valid = 1'b0;
        chk("same_next_old", bif.pc, 64'hA00);
        go(64'h10C); chk("same_new_tgt", bif.pred_target, 64'hB00);
        tick(); chk("same_new_next", bif.pc, 64'hB00);

        // Asynchronous reset mid-operation discards a pending update
        bif.upd_valid = 1'b1; bif.upd_pc = 64'h200;
        bif.upd_target = 64'h700; bif.upd_taken = 1'b1;
        #2; rst = 1'b0; #1;
        chk("async_rst_pc", bif.pc, 64'h0);
        chk("async_rst_valid", {63'h0, bif.pc_valid}, 64'h0);
        bif.upd_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick(); chk("rerel_valid", {63'h0, bif.pc_valid}, 64'h1);
        chk("rerel_pc", bif.pc, 64'h0);
        go(64'h40);  chk("rst_clears_btb", {63'h0, bif.pred_taken}, 64'h0);
        go(64'h200); chk("rst_drops_upd", {63'h0, bif.pred_taken}, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
